// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - I/D port arbiter for a shared unified memory (round-robin when MEM_ARB_RR_EN is defined)
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [CNT_W-1:0]  conflict_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   we_q;
    logic   i_elig;
    logic   d_elig;
    logic   conflict;
    logic   pick_d;

`ifdef MEM_ARB_RR_EN
    logic   last_d;
`endif

    // A port being served or in its ack cycle sits out the next arbitration
    always_comb begin
        i_elig    = i_req && !i_ack && (state != SERVE_I);
        d_elig    = d_req && !d_ack && (state != SERVE_D);
        conflict  = i_elig && d_elig;
`ifdef MEM_ARB_RR_EN
        pick_d    = d_elig && (!i_elig || !last_d);
`else
        pick_d    = d_elig;
`endif
        state_nxt = IDLE;
        if (pick_d) begin
            state_nxt = SERVE_D;
        end else if (i_elig) begin
            state_nxt = SERVE_I;
        end
    end

    // Store strobe derives from state so an async reset kills it before the negedge commit
    assign mem_write = (state == SERVE_D) && we_q;

    // State register, latched request, registered read data and acks, conflict counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            we_q         <= 1'b0;
            i_ack        <= 1'b0;
            d_ack        <= 1'b0;
            i_rdata      <= '0;
            d_rdata      <= '0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            conflict_cnt <= '0;
        end else begin
            state <= state_nxt;
            i_ack <= (state == SERVE_I);
            d_ack <= (state == SERVE_D);
            if (state == SERVE_I) begin
                i_rdata <= mem_rdata;
            end
            if ((state == SERVE_D) && !we_q) begin
                d_rdata <= mem_rdata;
            end
            if (state_nxt == SERVE_D) begin
                mem_addr  <= d_addr;
                mem_wdata <= d_wdata;
                we_q      <= d_we;
            end else if (state_nxt == SERVE_I) begin
                mem_addr  <= i_addr;
                we_q      <= 1'b0;
            end
            if (conflict && (conflict_cnt != '1)) begin
                conflict_cnt <= conflict_cnt + CNT_W'(1);
            end
        end
    end

`ifdef MEM_ARB_RR_EN
    // Remember which port entered SERVE last; the other one wins the next conflict
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_d <= 1'b0;
        end else if (state_nxt == SERVE_D) begin
            last_d <= 1'b1;
        end else if (state_nxt == SERVE_I) begin
            last_d <= 1'b0;
        end
    end
`endif

endmodule
